// File: rtl/block_mac_2x2_pkg.sv
// Shared definitions for the 2x2 block multiply-accumulate stage: FSM state
// encoding and the step counter geometry used by the MAC sequencer.
package block_mac_2x2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One multiply-add per cycle: two products for each of the four corners.
    localparam int MAC_STEPS  = 8;
    localparam int STEP_WIDTH = $clog2(MAC_STEPS);
    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(MAC_STEPS - 1);

endpackage

// File: rtl/block_mac_2x2_if.sv
// Handshake and data bundle between the matrix-multiplier controller (master)
// and one block_mac_2x2 compute stage (slave).
interface block_mac_2x2_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  ready;
    logic                  start;
    logic                  clear_acc;
    logic                  last;
    logic [DATA_WIDTH-1:0] a_ul, a_ur, a_dl, a_dr;
    logic [DATA_WIDTH-1:0] b_ul, b_ur, b_dl, b_dr;
    logic                  result_valid;
    logic [DATA_WIDTH-1:0] c_ul, c_ur, c_dl, c_dr;
    logic                  result_ack;

    modport master (
        input  ready, result_valid, c_ul, c_ur, c_dl, c_dr,
        output start, clear_acc, last,
        output a_ul, a_ur, a_dl, a_dr, b_ul, b_ur, b_dl, b_dr,
        output result_ack
    );

    modport slave (
        output ready, result_valid, c_ul, c_ur, c_dl, c_dr,
        input  start, clear_acc, last,
        input  a_ul, a_ur, a_dl, a_dr, b_ul, b_ur, b_dl, b_dr,
        input  result_ack
    );

endinterface

// File: rtl/block_mac_2x2_mac_lane.sv
// Single shared multiply-add lane: sum = (clear ? 0 : acc) + (acc_en ? a*b : 0).
// Only the low DATA_WIDTH bits of the signed product are ever kept, and those
// bits are identical whether the product is formed at full or at operand
// width, so the multiply is done at operand width. Sums wrap.
module mac_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic                  acc_en,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] sum
);

    logic [DATA_WIDTH-1:0] product;
    logic [DATA_WIDTH-1:0] base;

    // Pick the starting value, then optionally add the truncated product.
    always_comb begin
        product = a * b;
        base    = clear ? '0 : acc;
        sum     = acc_en ? (base + product) : base;
    end

endmodule

// File: rtl/block_mac_2x2.sv
// 2x2 block multiply-accumulate stage. Latches one A/B sub-block pair, runs
// eight sequential multiply-adds through a single mac_lane, and either waits
// for the next pair of the strip or presents the finished result square.
module block_mac_2x2
    import block_mac_2x2_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    block_mac_2x2_if.slave bus
);

    logic [DATA_WIDTH-1:0] op_a [2][2];
    logic [DATA_WIDTH-1:0] op_b [2][2];
    logic [DATA_WIDTH-1:0] acc  [4];

    state_t                state;
    logic [STEP_WIDTH-1:0] step;
    logic                  last_q;
    logic                  ready_q;
    logic                  valid_q;
    logic                  accept;

    logic [1:0]            target;
    logic [DATA_WIDTH-1:0] lane_a;
    logic [DATA_WIDTH-1:0] lane_b;
    logic [DATA_WIDTH-1:0] lane_acc;
    logic                  lane_en;
    logic                  lane_clr;
    logic [DATA_WIDTH-1:0] lane_sum;

    assign accept = bus.start && ready_q;

    // Step s updates corner s/2 (ul, ur, dl, dr) with term s%2 of its dot
    // product: A row from the corner, B column from the corner, inner index
    // from the low step bit. On acceptance with clear_acc the lane yields zero.
    always_comb begin
        target   = step[STEP_WIDTH-1:1];
        lane_a   = op_a[target[1]][step[0]];
        lane_b   = op_b[step[0]][target[0]];
        lane_acc = acc[target];
        lane_en  = (state == MAC);
        lane_clr = (state == IDLE) && accept && bus.clear_acc;
    end

    mac_lane #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
        .a      (lane_a),
        .b      (lane_b),
        .acc    (lane_acc),
        .acc_en (lane_en),
        .clear  (lane_clr),
        .sum    (lane_sum)
    );

    // Sequencer: accept a pair, step through the eight multiply-adds, then
    // return for more or hold the result until the consumer acknowledges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            step    <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < 2; k++) begin
                    op_a[r][k] <= '0;
                    op_b[r][k] <= '0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a[0][0] <= bus.a_ul;
                        op_a[0][1] <= bus.a_ur;
                        op_a[1][0] <= bus.a_dl;
                        op_a[1][1] <= bus.a_dr;
                        op_b[0][0] <= bus.b_ul;
                        op_b[0][1] <= bus.b_ur;
                        op_b[1][0] <= bus.b_dl;
                        op_b[1][1] <= bus.b_dr;
                        last_q     <= bus.last;
                        if (bus.clear_acc) begin
                            for (int i = 0; i < 4; i++) begin
                                acc[i] <= lane_sum;
                            end
                        end
                        step    <= '0;
                        ready_q <= 1'b0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    acc[target] <= lane_sum;
                    if (step == LAST_STEP) begin
                        step <= '0;
                        if (last_q) begin
                            valid_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.result_ack) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready        = ready_q;
    assign bus.result_valid = valid_q;
    assign bus.c_ul         = acc[0];
    assign bus.c_ur         = acc[1];
    assign bus.c_dl         = acc[2];
    assign bus.c_dr         = acc[3];

endmodule

// File: tb/tb_block_mac_2x2.sv
// Directed testbench for block_mac_2x2 with a result scoreboard: stimulus
// pushes hand-computed result squares, a monitor pops and compares them each
// time result_valid rises.
module tb_block_mac_2x2;

    typedef logic [31:0] quad_t [4];

    typedef struct packed {
        logic [31:0] ul;
        logic [31:0] ur;
        logic [31:0] dl;
        logic [31:0] dr;
    } square_t;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    square_t expQ[$];
    logic    validPrev = 1'b0;

    block_mac_2x2_if #(.DATA_WIDTH(32)) bus ();

    block_mac_2x2 #(
        .DATA_WIDTH(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got=0x%08h exp=0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: one comparison set per rising edge of result_valid.
    always @(negedge clk) begin
        if (bus.result_valid === 1'b1 && validPrev !== 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                square_t e;
                e = expQ.pop_front();
                checkOutput("c_ul", bus.c_ul, e.ul);
                checkOutput("c_ur", bus.c_ur, e.ur);
                checkOutput("c_dl", bus.c_dl, e.dl);
                checkOutput("c_dr", bus.c_dr, e.dr);
            end
        end
        validPrev = bus.result_valid;
    end

    // Issue one block pair at a negedge; returns at the negedge of cycle 1
    // with the operand inputs scrambled to prove they were latched.
    task automatic applyStimulus(input quad_t a, input quad_t b,
                                 input logic clr, input logic lst);
        checkOutput("ready_before_start", {31'd0, bus.ready}, 32'd1);
        bus.a_ul = a[0]; bus.a_ur = a[1]; bus.a_dl = a[2]; bus.a_dr = a[3];
        bus.b_ul = b[0]; bus.b_ur = b[1]; bus.b_dl = b[2]; bus.b_dr = b[3];
        bus.clear_acc = clr;
        bus.last      = lst;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.clear_acc = 1'b0;
        bus.last      = 1'b0;
        bus.a_ul = 32'hDEADBEEF; bus.a_ur = 32'h12345678;
        bus.a_dl = 32'hCAFEF00D; bus.a_dr = 32'h0BADC0DE;
        bus.b_ul = 32'h55AA55AA; bus.b_ur = 32'hA5A5A5A5;
        bus.b_dl = 32'h0F0F0F0F; bus.b_dr = 32'hFFFFFFFF;
    endtask

    // Full pair with latency checks; returns at the negedge of cycle 9.
    task automatic runPair(input quad_t a, input quad_t b,
                           input logic clr, input logic lst);
        applyStimulus(a, b, clr, lst);
        checkOutput("ready_low_c1", {31'd0, bus.ready}, 32'd0);
        repeat (7) @(negedge clk);
        checkOutput("ready_low_c8", {31'd0, bus.ready}, 32'd0);
        checkOutput("valid_low_c8", {31'd0, bus.result_valid}, 32'd0);
        @(negedge clk);
        if (lst) begin
            checkOutput("valid_high_c9", {31'd0, bus.result_valid}, 32'd1);
            checkOutput("ready_low_c9", {31'd0, bus.ready}, 32'd0);
        end else begin
            checkOutput("valid_low_c9", {31'd0, bus.result_valid}, 32'd0);
            checkOutput("ready_high_c9", {31'd0, bus.ready}, 32'd1);
        end
    endtask

    // Acknowledge the presented result and confirm the stage is free again.
    task automatic ackResult();
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        checkOutput("valid_after_ack", {31'd0, bus.result_valid}, 32'd0);
        checkOutput("ready_after_ack", {31'd0, bus.ready}, 32'd1);
    endtask

    function automatic square_t sq(input logic [31:0] ul, input logic [31:0] ur,
                                   input logic [31:0] dl, input logic [31:0] dr);
        square_t s;
        s.ul = ul; s.ur = ur; s.dl = dl; s.dr = dr;
        return s;
    endfunction

    initial begin
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.clear_acc  = 1'b0;
        bus.last       = 1'b0;
        bus.result_ack = 1'b0;
        bus.a_ul = '0; bus.a_ur = '0; bus.a_dl = '0; bus.a_dr = '0;
        bus.b_ul = '0; bus.b_ur = '0; bus.b_dl = '0; bus.b_dr = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_ready", {31'd0, bus.ready}, 32'd1);
        checkOutput("reset_valid", {31'd0, bus.result_valid}, 32'd0);
        checkOutput("reset_c_ul", bus.c_ul, 32'd0);
        checkOutput("reset_c_dr", bus.c_dr, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Stray acknowledge with nothing pending has no effect.
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        checkOutput("stray_ack_ready", {31'd0, bus.ready}, 32'd1);
        checkOutput("stray_ack_valid", {31'd0, bus.result_valid}, 32'd0);

        $display("[TB] basic single-block product");
        expQ.push_back(sq(32'd19, 32'd22, 32'd43, 32'd50));
        runPair('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b1, 1'b1);
        ackResult();

        $display("[TB] two-pair accumulation");
        runPair('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b1, 1'b0);
        checkOutput("partial_c_ul", bus.c_ul, 32'd19);
        checkOutput("partial_c_dr", bus.c_dr, 32'd50);
        expQ.push_back(sq(32'd38, 32'd44, 32'd86, 32'd100));
        runPair('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b0, 1'b1);
        ackResult();

        $display("[TB] signed operands");
        expQ.push_back(sq(32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'hFFFFFFFA));
        runPair('{32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF},
                '{32'd3, 32'd4, 32'd5, 32'd6}, 1'b1, 1'b1);
        ackResult();

        $display("[TB] wrap-around");
        expQ.push_back(sq(32'd0, 32'd0, 32'd0, 32'd0));
        runPair('{32'h80000000, 32'd0, 32'd0, 32'd0}, '{32'd2, 32'd0, 32'd0, 32'd0}, 1'b1, 1'b1);
        ackResult();
        expQ.push_back(sq(32'd1, 32'd0, 32'd0, 32'd0));
        runPair('{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0}, '{32'h7FFFFFFF, 32'd0, 32'd0, 32'd0}, 1'b1, 1'b1);
        ackResult();

        $display("[TB] backpressure");
        expQ.push_back(sq(32'd19, 32'd22, 32'd43, 32'd50));
        runPair('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b1, 1'b1);
        bus.a_ul = 32'd9; bus.b_ul = 32'd9; bus.clear_acc = 1'b1; bus.last = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, bus.result_valid}, 32'd1);
            checkOutput("hold_ready", {31'd0, bus.ready}, 32'd0);
            checkOutput("hold_c_ul", bus.c_ul, 32'd19);
            checkOutput("hold_c_dr", bus.c_dr, 32'd50);
        end
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        bus.start      = 1'b0;
        bus.clear_acc  = 1'b0;
        bus.last       = 1'b0;
        checkOutput("start_with_ack_ignored", {31'd0, bus.ready}, 32'd1);
        checkOutput("c_kept_after_ack", bus.c_ur, 32'd22);
        expQ.push_back(sq(32'd2, 32'd4, 32'd6, 32'd8));
        runPair('{32'd2, 32'd0, 32'd0, 32'd2}, '{32'd1, 32'd2, 32'd3, 32'd4}, 1'b1, 1'b1);
        ackResult();

        $display("[TB] reset during MAC");
        applyStimulus('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("midmac_ready", {31'd0, bus.ready}, 32'd1);
        checkOutput("midmac_valid", {31'd0, bus.result_valid}, 32'd0);
        checkOutput("midmac_c_ul", bus.c_ul, 32'd0);
        checkOutput("midmac_c_ur", bus.c_ur, 32'd0);
        checkOutput("midmac_c_dl", bus.c_dl, 32'd0);
        checkOutput("midmac_c_dr", bus.c_dr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expQ.push_back(sq(32'd4, 32'd6, 32'd4, 32'd6));
        runPair('{32'd1, 32'd1, 32'd1, 32'd1}, '{32'd1, 32'd2, 32'd3, 32'd4}, 1'b1, 1'b1);
        ackResult();

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_mac_2x2.md
Name: block_mac_2x2

Overview:
- Downstream compute stage of the matrix-multiplier controller.
- Accepts one 2x2 sub-block of the first matrix (A) and one 2x2 sub-block of the second matrix (B), computes A·B, and accumulates it into a 2x2 running sum.
- After the last block pair of a dot-product strip, presents the 2x2 result square for write-back.
- The controller instantiates three copies and dispatches to whichever asserts ready.

Parameters:
- DATA_WIDTH, 32, width of every operand, accumulator and result element; two's-complement integer.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ready  output  1  high when a new block pair can be accepted.
- start  input  1  block-pair strobe; accepted only when start && ready.
- clear_acc  input  1  sampled with start; zero the accumulators before this pair.
- last  input  1  sampled with start; this pair completes the result square.
- a_ul, a_ur, a_dl, a_dr  input  DATA_WIDTH each  A sub-block: up-left, up-right, down-left, down-right.
- b_ul, b_ur, b_dl, b_dr  input  DATA_WIDTH each  B sub-block: same corner order.
- result_valid  output  1  result square available.
- c_ul, c_ur, c_dl, c_dr  output  DATA_WIDTH each  accumulated result corners.
- result_ack  input  1  consumer has taken the result.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, ready=1, result_valid=0.
  - c_* = 0, operand latches = 0, step counter = 0.
- States:
  - IDLE: ready=1. On start, latch the 8 operands, clear_acc and last; if clear_acc, zero c_*; step=0; go to MAC.
  - MAC: ready=0, 8 cycles, one multiply-add per cycle. Steps 0..7:
    - c_ul += a_ul*b_ul, then a_ur*b_dl
    - c_ur += a_ul*b_ur, then a_ur*b_dr
    - c_dl += a_dl*b_ul, then a_dr*b_dl
    - c_dr += a_dl*b_ur, then a_dr*b_dr
    - After step 7: if the latched last=1, go to DONE; else go to IDLE with accumulators retained.
  - DONE: result_valid=1, ready=0, c_* held stable. On result_ack, result_valid goes to 0 next cycle, state goes to IDLE, and c_* are left as-is. The next pair must carry clear_acc=1 to start a new square.
- Latency:
  - Start accepted at edge 0.
  - ready low from cycle 1 through cycle 8.
  - result_valid high from cycle 9 when last=1; otherwise ready returns high at cycle 9.
  - Throughput: one block pair per 9 cycles.
- Arithmetic:
  - Full 2*DATA_WIDTH signed product, truncated to the low DATA_WIDTH bits.
  - Addition wraps modulo 2^DATA_WIDTH.
  - No saturation, no overflow flag.
- Boundaries:
  - start while ready=0: ignored, no state change.
  - result_ack while result_valid=0: ignored.
  - start in the same cycle as result_ack in DONE: start ignored (ready=0).
  - Input operands may change after acceptance without effect.
  - clear_acc=1 with last=1: single-block result (A·B only).
  - reset asserted mid-MAC or in DONE: immediate return to reset values; the partial sum is discarded.

Decomposition:
- Shared package: state encoding (IDLE, MAC, DONE) and the step-count constant MAC_STEPS=8.
- One natural sub-module, mac_lane: signed multiply, truncate, and add with accumulator-enable and clear inputs.
- block_mac_2x2 uses a single mac_lane, multiplexing operands and accumulator by step number.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], clear_acc=1, last=1 -> cycle 9: result_valid=1, c=[[19,22],[43,50]]; ready=1 the cycle after result_ack.
- Same pair twice: first with clear_acc=1, last=0; second with clear_acc=0, last=1 -> after the first, ready=1 and result_valid=0; after the second, c=[[38,44],[86,100]].
- Signed: A=[[-1,0],[0,-1]], B=[[3,4],[5,6]] -> c=[[-3,-4],[-5,-6]] (0xFFFFFFFD, 0xFFFFFFFC, 0xFFFFFFFB, 0xFFFFFFFA).
- Wrap: a_ul=0x80000000, b_ul=2, all other operands 0 -> c_ul=0x00000000; a_ul=0x7FFFFFFF, b_ul=0x7FFFFFFF -> c_ul=0x00000001.
- Backpressure: hold result_ack=0 for 5 cycles and pulse start with new data -> result_valid, c_* and ready=0 all stable, start ignored; ack then a fresh start -> processed normally.
- Reset mid-MAC at step 4 -> same cycle: ready=1, result_valid=0, c_*=0; a following single-block start yields the correct fresh result.
